// File: rtl/cr16_alu_arbiter.sv
// cr16_alu_arbiter: shares one CR16 ALU between the CPU execute stage (requester 0)
// and the auxiliary/DMA engine (requester 1).
//   - Round-robin grant in IDLE. An optional lock lets a requester chain ops without
//     interleaving. A lock left idle for P_LOCK_TIMEOUT cycles is force-released.
//   - Each op runs IDLE (handshake) -> ISSUE (ALU enable) -> RESULT (capture) -> IDLE.
//   - Each requester has its own shadow copy of the ALU status.
// Ports:
//   I_CLK, I_RESET (sync, active high)
//   I_REQx_VALID/LOCK/OPCODE/A/B, O_REQx_READY : requester handshake (x = 0, 1)
//   O_RSPx_VALID : one-cycle completion pulse
//   O_RSP_C : shared result
//   O_RSPx_STATUS : per-requester status
//   O_ALU_ENABLE/OPCODE/A/B, I_ALU_C/STATUS : ALU side
module cr16_alu_arbiter #(
  parameter int unsigned P_WIDTH        = 16,
  parameter int unsigned P_STATUS_WIDTH = 5,
  parameter int unsigned P_LOCK_TIMEOUT = 8
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET,
  input  logic                      I_REQ0_VALID,
  output logic                      O_REQ0_READY,
  input  logic                      I_REQ0_LOCK,
  input  logic [3:0]                I_REQ0_OPCODE,
  input  logic [P_WIDTH-1:0]        I_REQ0_A,
  input  logic [P_WIDTH-1:0]        I_REQ0_B,
  input  logic                      I_REQ1_VALID,
  output logic                      O_REQ1_READY,
  input  logic                      I_REQ1_LOCK,
  input  logic [3:0]                I_REQ1_OPCODE,
  input  logic [P_WIDTH-1:0]        I_REQ1_A,
  input  logic [P_WIDTH-1:0]        I_REQ1_B,
  output logic                      O_RSP0_VALID,
  output logic                      O_RSP1_VALID,
  output logic [P_WIDTH-1:0]        O_RSP_C,
  output logic [P_STATUS_WIDTH-1:0] O_RSP0_STATUS,
  output logic [P_STATUS_WIDTH-1:0] O_RSP1_STATUS,
  output logic                      O_ALU_ENABLE,
  output logic [3:0]                O_ALU_OPCODE,
  output logic [P_WIDTH-1:0]        O_ALU_A,
  output logic [P_WIDTH-1:0]        O_ALU_B,
  input  logic [P_WIDTH-1:0]        I_ALU_C,
  input  logic [P_STATUS_WIDTH-1:0] I_ALU_STATUS
);

  typedef enum logic [1:0] {StIdle, StIssue, StResult} state_e;

  localparam int unsigned CntW = $clog2(P_LOCK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(P_LOCK_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic                      ptr_q, ptr_d;
  logic                      lock_q, lock_d;
  logic                      lock_owner_q, lock_owner_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      owner_q;
  logic                      lock_req_q;
  logic [3:0]                op_q;
  logic [P_WIDTH-1:0]        a_q, b_q;
  logic                      rsp0_valid_q, rsp1_valid_q;
  logic [P_WIDTH-1:0]        rsp_c_q;
  logic [P_STATUS_WIDTH-1:0] status0_q, status1_q;
  logic                      grant0, grant1, handshake, owner_valid;

  // Grant selection; only meaningful in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (lock_q) begin
        grant0 = !lock_owner_q && I_REQ0_VALID;
        grant1 = lock_owner_q && I_REQ1_VALID;
      end else if (I_REQ0_VALID && I_REQ1_VALID) begin
        grant0 = !ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = I_REQ0_VALID;
        grant1 = I_REQ1_VALID;
      end
    end
  end

  assign handshake   = grant0 || grant1;
  assign owner_valid = lock_owner_q ? I_REQ1_VALID : I_REQ0_VALID;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StIssue;
          ptr_d   = !grant1;
          cnt_d   = '0;
        end else if (lock_q && !owner_valid) begin
          // Owner is idling on the ALU; release once the budget is spent.
          if (cnt_q == CntLast) begin
            lock_d = 1'b0;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StIssue: state_d = StResult;
      StResult: begin
        state_d      = StIdle;
        lock_d       = lock_req_q;
        lock_owner_d = owner_q;
        cnt_d        = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      lock_req_q   <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_c_q      <= '0;
      status0_q    <= '0;
      status1_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      cnt_q        <= cnt_d;
      if (handshake) begin
        owner_q    <= grant1;
        lock_req_q <= grant1 ? I_REQ1_LOCK : I_REQ0_LOCK;
        op_q       <= grant1 ? I_REQ1_OPCODE : I_REQ0_OPCODE;
        a_q        <= grant1 ? I_REQ1_A : I_REQ0_A;
        b_q        <= grant1 ? I_REQ1_B : I_REQ0_B;
      end
      rsp0_valid_q <= (state_q == StResult) && !owner_q;
      rsp1_valid_q <= (state_q == StResult) && owner_q;
      if (state_q == StResult) begin
        rsp_c_q <= I_ALU_C;
        if (owner_q) status1_q <= I_ALU_STATUS;
        else         status0_q <= I_ALU_STATUS;
      end
    end
  end

  assign O_REQ0_READY  = grant0;
  assign O_REQ1_READY  = grant1;
  assign O_RSP0_VALID  = rsp0_valid_q;
  assign O_RSP1_VALID  = rsp1_valid_q;
  assign O_RSP_C       = rsp_c_q;
  assign O_RSP0_STATUS = status0_q;
  assign O_RSP1_STATUS = status1_q;
  assign O_ALU_ENABLE  = (state_q == StIssue);
  assign O_ALU_OPCODE  = op_q;
  assign O_ALU_A       = a_q;
  assign O_ALU_B       = b_q;

endmodule

// File: tb/tb_cr16_alu_arbiter.sv
// Directed bench for cr16_alu_arbiter with a small behavioural ALU attached.
module tb_cr16_alu_arbiter;

  logic        clk, rst;
  logic        r0_valid, r0_ready, r0_lock;
  logic [3:0]  r0_op;
  logic [15:0] r0_a, r0_b;
  logic        r1_valid, r1_ready, r1_lock;
  logic [3:0]  r1_op;
  logic [15:0] r1_a, r1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_c;
  logic [4:0]  st0, st1;
  logic        alu_en;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_st;

  int n_checks = 0;
  int n_pass   = 0;

  cr16_alu_arbiter dut (
    .I_CLK        (clk),
    .I_RESET      (rst),
    .I_REQ0_VALID (r0_valid),
    .O_REQ0_READY (r0_ready),
    .I_REQ0_LOCK  (r0_lock),
    .I_REQ0_OPCODE(r0_op),
    .I_REQ0_A     (r0_a),
    .I_REQ0_B     (r0_b),
    .I_REQ1_VALID (r1_valid),
    .O_REQ1_READY (r1_ready),
    .I_REQ1_LOCK  (r1_lock),
    .I_REQ1_OPCODE(r1_op),
    .I_REQ1_A     (r1_a),
    .I_REQ1_B     (r1_b),
    .O_RSP0_VALID (rsp0_valid),
    .O_RSP1_VALID (rsp1_valid),
    .O_RSP_C      (rsp_c),
    .O_RSP0_STATUS(st0),
    .O_RSP1_STATUS(st1),
    .O_ALU_ENABLE (alu_en),
    .O_ALU_OPCODE (alu_op),
    .O_ALU_A      (alu_a),
    .O_ALU_B      (alu_b),
    .I_ALU_C      (alu_c),
    .I_ALU_STATUS (alu_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: 0 ADD, 1 ADDU, 2 ADDCU, 3 SUB (B-A); anything else returns zeros.
  // Status = {neg, zero, flag(overflow), low(0), carry}.
  function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic        ov, cy;
    s = 17'd0; r = 16'd0; ov = 1'b0; cy = 1'b0;
    case (op)
      4'd0, 4'd1, 4'd2: begin
        s  = {1'b0, a} + {1'b0, b} + {16'd0, (op == 4'd2) & cin};
        r  = s[15:0];
        cy = s[16];
        ov = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd3: begin
        r  = b - a;
        ov = (b[15] != a[15]) && (r[15] != b[15]);
      end
      default: return 21'd0;
    endcase
    return {r[15], r == 16'd0, ov, 1'b0, cy, r};
  endfunction

  initial begin
    alu_c  = 16'd0;
    alu_st = 5'd0;
  end
  always @(posedge clk) begin
    if (alu_en) {alu_st, alu_c} <= alu_model(alu_op, alu_a, alu_b, alu_st[0]);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    r0_valid = 0; r0_lock = 0; r0_op = 0; r0_a = 0; r0_b = 0;
    r1_valid = 0; r1_lock = 0; r1_op = 0; r1_a = 0; r1_b = 0;
  endtask

  // Ends just after a negedge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_c, st0, st1, alu_en, alu_op, alu_a, alu_b} !== 64'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {rsp0_valid, rsp1_valid, rsp_c, st0, st1, alu_en, alu_op, alu_a, alu_b});
    else n_pass++;
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00",
                                                 {r0_ready, r1_ready});
    else n_pass++;
  endtask

  task automatic test_add();
    do_reset();
    r0_valid = 1; r0_op = 4'd0; r0_a = 16'h7FFF; r0_b = 16'h0001;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL add_ready: got %b want 10",
                                                 {r0_ready, r1_ready});
    else n_pass++;
    @(negedge clk);
    r0_valid = 0; r0_a = 16'hDEAD; r0_b = 16'hBEEF;
    #1;
    n_checks++;
    if ({alu_en, alu_op, alu_a, alu_b} !== {1'b1, 4'd0, 16'h7FFF, 16'h0001})
      $display("FAIL add_issue: got %h want %h", {alu_en, alu_op, alu_a, alu_b},
               {1'b1, 4'd0, 16'h7FFF, 16'h0001});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp0_valid, alu_en} !== 2'b00) $display("FAIL add_result_cycle: got %b want 00",
                                                 {rsp0_valid, alu_en});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_c, st0, st1} !== {2'b10, 16'h8000, 5'b10100, 5'b00000})
      $display("FAIL add_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp_c, st0, st1},
               {2'b10, 16'h8000, 5'b10100, 5'b00000});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (rsp0_valid !== 1'b0) $display("FAIL add_pulse_len: got %b want 0", rsp0_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_c;
    logic [4:0]  exp_st1;
    do_reset();
    r0_valid = 1; r0_op = 4'd1; r0_a = 16'hFFFF; r0_b = 16'h0001;
    r1_valid = 1; r1_op = 4'd3; r1_a = 16'd5;    r1_b = 16'd3;
    #1;
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if ({r0_ready, r1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL b2b_grant%0d: got %b want %b", g, {r0_ready, r1_ready},
                 (g % 2 == 0) ? 2'b10 : 2'b01);
      else n_pass++;
      repeat (3) @(negedge clk);
      #1;
      exp_c   = (g % 2 == 0) ? 16'h0000 : 16'hFFFE;
      exp_st1 = (g == 0) ? 5'b00000 : 5'b10000;
      n_checks++;
      if ({rsp0_valid, rsp1_valid, rsp_c, st0, st1} !==
          {(g % 2 == 0), (g % 2 == 1), exp_c, 5'b01001, exp_st1})
        $display("FAIL b2b_rsp%0d: got %h want %h", g, {rsp0_valid, rsp1_valid, rsp_c, st0, st1},
                 {(g % 2 == 0), (g % 2 == 1), exp_c, 5'b01001, exp_st1});
      else n_pass++;
      if (g == 3) begin
        r0_valid = 0;
        r1_valid = 0;
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    r1_valid = 1; r1_lock = 1; r1_op = 4'd1; r1_a = 16'hFFFF; r1_b = 16'h0001;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b01) $display("FAIL lock_first: got %b want 01",
                                                 {r0_ready, r1_ready});
    else n_pass++;
    @(negedge clk);
    r0_valid = 1; r0_op = 4'd0; r0_a = 16'd1; r0_b = 16'd1;
    r1_op = 4'd2; r1_a = 16'd0; r1_b = 16'd0; r1_lock = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp1_valid, rsp_c, st1, r0_ready, r1_ready} !== {1'b1, 16'h0000, 5'b01001, 2'b01})
      $display("FAIL lock_held: got %h want %h", {rsp1_valid, rsp_c, st1, r0_ready, r1_ready},
               {1'b1, 16'h0000, 5'b01001, 2'b01});
    else n_pass++;
    @(negedge clk);
    r1_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp1_valid, rsp_c, st1, r0_ready, r1_ready} !== {1'b1, 16'h0001, 5'b00000, 2'b10})
      $display("FAIL lock_chain_done: got %h want %h",
               {rsp1_valid, rsp_c, st1, r0_ready, r1_ready}, {1'b1, 16'h0001, 5'b00000, 2'b10});
    else n_pass++;
    @(negedge clk);
    r0_valid = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    r0_valid = 1; r0_lock = 1; r0_op = 4'd0; r0_a = 16'd1; r0_b = 16'd1;
    #1;
    n_checks++;
    if (r0_ready !== 1'b1) $display("FAIL tmo_grant0: got %b want 1", r0_ready);
    else n_pass++;
    @(negedge clk);
    r0_valid = 0; r0_lock = 0;
    r1_valid = 1; r1_op = 4'd1; r1_a = 16'd2; r1_b = 16'd3;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (r1_ready !== 1'b0) $display("FAIL tmo_blocked%0d: got %b want 0", i, r1_ready);
      else n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (r1_ready !== 1'b1) $display("FAIL tmo_release: got %b want 1", r1_ready);
    else n_pass++;
    @(negedge clk);
    r1_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp1_valid, rsp_c, st1} !== {1'b1, 16'h0005, 5'b00000})
      $display("FAIL tmo_rsp1: got %h want %h", {rsp1_valid, rsp_c, st1},
               {1'b1, 16'h0005, 5'b00000});
    else n_pass++;
  endtask

  task automatic test_reset_in_result();
    do_reset();
    r0_valid = 1; r0_op = 4'd0; r0_a = 16'h7FFF; r0_b = 16'h0001;
    @(negedge clk);
    r0_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp0_valid, rsp_c} !== {1'b1, 16'h8000})
      $display("FAIL rir_pre: got %h want %h", {rsp0_valid, rsp_c}, {1'b1, 16'h8000});
    else n_pass++;
    r0_valid = 1; r0_a = 16'd1; r0_b = 16'd2;
    @(negedge clk);
    r0_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_c, st0, st1, alu_en, alu_op, alu_a, alu_b} !== 64'd0)
      $display("FAIL rir_cleared: got %h want 0",
               {rsp0_valid, rsp1_valid, rsp_c, st0, st1, alu_en, alu_op, alu_a, alu_b});
    else n_pass++;
    r0_valid = 1; r1_valid = 1;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL rir_ptr: got %b want 10",
                                                 {r0_ready, r1_ready});
    else n_pass++;
    r0_valid = 0; r1_valid = 0;
  endtask

  task automatic test_opcode15();
    do_reset();
    r1_valid = 1; r1_op = 4'd1; r1_a = 16'hFFFF; r1_b = 16'h0002;
    @(negedge clk);
    r1_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp1_valid, rsp_c, st1} !== {1'b1, 16'h0001, 5'b00001})
      $display("FAIL op15_pre: got %h want %h", {rsp1_valid, rsp_c, st1},
               {1'b1, 16'h0001, 5'b00001});
    else n_pass++;
    r1_valid = 1; r1_op = 4'd15; r1_a = 16'h1234; r1_b = 16'h5678;
    #1;
    n_checks++;
    if (r1_ready !== 1'b1) $display("FAIL op15_ready: got %b want 1", r1_ready);
    else n_pass++;
    @(negedge clk);
    r1_valid = 0;
    #1;
    n_checks++;
    if ({alu_en, alu_op, alu_a, alu_b} !== {1'b1, 4'd15, 16'h1234, 16'h5678})
      $display("FAIL op15_issue: got %h want %h", {alu_en, alu_op, alu_a, alu_b},
               {1'b1, 4'd15, 16'h1234, 16'h5678});
    else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp1_valid, rsp_c, st1} !== {1'b1, 16'h0000, 5'b00000})
      $display("FAIL op15_rsp: got %h want %h", {rsp1_valid, rsp_c, st1},
               {1'b1, 16'h0000, 5'b00000});
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_add();
    test_back_to_back();
    test_lock();
    test_timeout();
    test_reset_in_result();
    test_opcode15();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cr16_alu_arbiter.md
Name: cr16_alu_arbiter

Overview:
- Shares the single CR16 ALU between two requesters: requester 0 is the CPU execute stage and requester 1 is the auxiliary/DMA engine.
- Arbitration is round-robin, with an optional lock so a requester can chain multi-op sequences (e.g. ADDU then ADDCU for 32-bit adds) without interleaving.
- Keeps a per-requester shadow copy of the ALU status, so one requester's flags never clobber the other's.
- Sits between the requesters and the ALU; it drives the ALU enable/opcode/operands and captures the ALU's registered result.

Parameters:
P_WIDTH, 16, datapath width of operands/result
P_STATUS_WIDTH, 5, ALU status width (bits: 0 carry, 1 low, 2 flag, 3 zero, 4 negative)
P_LOCK_TIMEOUT, 8, idle cycles a lock owner may leave the ALU unused before the lock is force-released

Ports:
I_CLK  in  1  clock
I_RESET  in  1  synchronous active-high reset
I_REQ0_VALID  in  1  requester 0 has an op
O_REQ0_READY  out  1  requester 0 op accepted this cycle
I_REQ0_LOCK  in  1  keep grant after this op completes
I_REQ0_OPCODE  in  4  ALU opcode
I_REQ0_A  in  P_WIDTH  operand A
I_REQ0_B  in  P_WIDTH  operand B
I_REQ1_VALID, O_REQ1_READY, I_REQ1_LOCK, I_REQ1_OPCODE, I_REQ1_A, I_REQ1_B  same as requester 0
O_RSP0_VALID  out  1  one-cycle pulse: requester 0 result ready
O_RSP1_VALID  out  1  one-cycle pulse: requester 1 result ready
O_RSP_C  out  P_WIDTH  result of last completed op (shared)
O_RSP0_STATUS  out  P_STATUS_WIDTH  requester 0 shadow status
O_RSP1_STATUS  out  P_STATUS_WIDTH  requester 1 shadow status
O_ALU_ENABLE  out  1  ALU enable
O_ALU_OPCODE  out  4  ALU opcode
O_ALU_A  out  P_WIDTH  ALU operand A
O_ALU_B  out  P_WIDTH  ALU operand B
I_ALU_C  in  P_WIDTH  ALU result
I_ALU_STATUS  in  P_STATUS_WIDTH  ALU status

Behaviour:
- Reset (sync, active high, takes priority everywhere):
  - State goes to IDLE; every registered output is cleared to 0.
  - Round-robin pointer goes to requester 0; lock is cleared; timeout counter is cleared.
  - Any in-flight op is dropped and no response is issued.
- ALU contract: when O_ALU_ENABLE=1 at edge E, I_ALU_C/I_ALU_STATUS are valid in the cycle after E and stay held while the enable is low.
- State IDLE:
  - The winner gets a combinational O_REQx_READY=1 (at most one READY high).
  - Unlocked winner: the valid requester named by the pointer; if only one is valid, that one.
  - Locked: only the lock owner can be granted; the other's READY is held 0.
  - On handshake (VALID&READY at the edge): latch opcode/A/B/LOCK and owner, move the pointer to the other requester, go to ISSUE.
- State ISSUE (1 cycle): O_ALU_ENABLE=1; O_ALU_OPCODE/A/B come from the latch registers (always driven from them, held otherwise). Next state is RESULT.
- State RESULT (1 cycle), capture at the edge:
  - O_RSP_C <= I_ALU_C.
  - Owner's shadow status <= I_ALU_STATUS; the other requester's shadow status is unchanged.
  - Owner's O_RSPx_VALID <= 1 for exactly one cycle.
  - Lock owner <= owner if latched LOCK=1, else lock cleared.
  - Next state is IDLE.
- Timing and throughput:
  - For a handshake at edge T, O_RSPx_VALID is high in cycle T+3.
  - A new grant may occur in cycle T+3, so throughput is one op per 3 cycles.
- Lock timeout:
  - While locked in IDLE with the owner's VALID=0, the counter increments each cycle.
  - When the counter reaches P_LOCK_TIMEOUT, the lock is released and the counter cleared; normal round-robin resumes in the next cycle.
  - The counter is cleared on any owner handshake.
- Simultaneous requests, unlocked: the pointer decides; strict alternation under continuous contention.
- Opcodes 14/15 are forwarded unchanged; the ALU returns C=0 and status=0, and these are passed through as a normal completion.
- Requester inputs are ignored outside the IDLE handshake; operand changes after acceptance do not affect the op.

Test Plan:
- Reset, then req0 ADD (op 0) A=0x7FFF B=0x0001 -> READY0 in the request cycle; RSP0_VALID exactly 3 cycles after the handshake; O_RSP_C=0x8000, RSP0_STATUS=5'b10100; RSP1_STATUS stays 0.
- Both valid every cycle: req0 ADDU 0xFFFF+0x0001, req1 SUB A=5 B=3 -> grants alternate 0,1,0,1; RSP0_STATUS=5'b01001 with C=0x0000; RSP1_STATUS=5'b10000 with C=0xFFFE; RSP1_STATUS is unchanged by req0 completions.
- req1 issues ADDU with LOCK=1, req0 continuously valid -> READY0 held 0 until req1's follow-up ADDCU with LOCK=0 completes; req0 is granted in the following IDLE cycle.
- req0 locks then drops VALID for 8 cycles while req1 is valid -> lock released after 8 IDLE cycles, READY1 in the next cycle.
- I_RESET asserted in the RESULT cycle -> no RSP valid pulse; all outputs 0; O_ALU_ENABLE 0; the next request is granted to req0 first.
- Opcode 15, A=0x1234 B=0x5678 -> RSP valid pulse with C=0x0000 and status 0.
